truth_table_sweeper: RTL and testbench

- Sequencer that characterises an N-input, 1-output combinational gate-level circuit.
- Drives every input vector 0..2^N-1 in ascending order, waits a settle interval, samples the output, and assembles the measured truth table.
- Compares the measured table against an expected table and reports the result.
- Sits between the test/config controller and a synthesized logic block in the netlist verification harness.

---
 rtl/truth_table_sweeper.sv | 115 +++++++++++
 tb/tb_truth_table_sweeper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps an N_IN-input circuit through every input vector, samples its
// output after a settle interval, and compares the measured truth table to an expected one.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic                   match,
  output logic [N_IN-1:0]        mismatch_idx
);
  localparam int TW = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);

  if (SETTLE < 1 || N_IN < 1 || N_IN > 6) begin : g_bad_param
    $error("truth_table_sweeper: illegal N_IN or SETTLE");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;

  state_t          state_q;
  logic [N_IN-1:0] idx_q, dut_in_q, mis_q, mis_d;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   exp_q, tt_q, tt_d, diff_d;
  logic            busy_q, done_q, aborted_q, match_q;

  // tt_d is the table as it will look once the current vector's sample is stored
  always_comb begin
    tt_d = tt_q;
    tt_d[idx_q] = dut_out;
    diff_d = tt_d ^ exp_q;
    mis_d = '0;
    for (int i = TW - 1; i >= 0; i--)
      if (diff_d[i]) mis_d = N_IN'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      tt_q      <= '0;
      dut_in_q  <= '0;
      mis_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          exp_q     <= expected;
          tt_q      <= '0;
          match_q   <= 1'b0;
          mis_q     <= '0;
          aborted_q <= 1'b0;
          idx_q     <= '0;
          cnt_q     <= '0;
          dut_in_q  <= '0;
          busy_q    <= 1'b1;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: if (abort) begin
          state_q   <= S_FINISH;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          dut_in_q  <= '0;
          aborted_q <= 1'b1;
          match_q   <= 1'b0;
          mis_q     <= idx_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(SETTLE - 1)) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          tt_q <= tt_d;
          if (abort || idx_q == {N_IN{1'b1}}) begin
            state_q   <= S_FINISH;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            dut_in_q  <= '0;
            aborted_q <= abort;
            match_q   <= !abort && diff_d == '0;
            mis_q     <= abort ? idx_q : mis_d;
          end else begin
            idx_q    <= idx_q + 1'b1;
            dut_in_q <= idx_q + 1'b1;
            cnt_q    <= '0;
            state_q  <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign truth_table  = tt_q;
  assign match        = match_q;
  assign mismatch_idx = mis_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper against hand-computed tables,
// using a default instance (3 inputs, settle 2) and a small one (2 inputs, settle 1).
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] expected = '0;
  logic [2:0] dut_in;
  logic       dut_out, busy, done, aborted, match;
  logic [7:0] truth_table;
  logic [2:0] mismatch_idx;

  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [3:0] expected2 = '0;
  logic [1:0] dut_in2;
  logic       dut_out2, busy2, done2, aborted2, match2;
  logic [3:0] truth_table2;
  logic [1:0] mismatch_idx2;

  int checks = 0, errors = 0, n = 0, bad = 0;

  always #5 clk = ~clk;

  // circuits under characterisation: inp1 & inp2 & ~inp3, and a 2-input XOR
  assign dut_out  = dut_in[2] & dut_in[1] & ~dut_in[0];
  assign dut_out2 = dut_in2[1] ^ dut_in2[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .aborted(aborted),
    .truth_table(truth_table), .match(match), .mismatch_idx(mismatch_idx));

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(expected2),
    .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2), .aborted(aborted2),
    .truth_table(truth_table2), .match(match2), .mismatch_idx(mismatch_idx2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start a sweep; optionally re-pulse start with a different expected at cycle poke,
  // or assert abort at cycle abort_at; n returns the number of busy cycles seen
  task automatic sweep(input logic [7:0] e, input int poke, input int abort_at);
    expected = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    bad = 0;
    while (busy && n < 100) begin
      if (dut_in !== 3'(n / 3)) bad++;
      start = (n == poke);
      if (n == poke) expected = ~e;
      abort = (n == abort_at);
      tick();
      n++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dut_in", dut_in, 0);
    chk("reset_table", truth_table, 0);
    chk("reset_match", match, 0);
    chk("reset_mis", mismatch_idx, 0);
    chk("reset_aborted", aborted, 0);
    rst_n = 1'b1;
    tick();

    // full sweep, expected matches; abort with start in IDLE is ignored
    abort = 1'b1;
    sweep(8'h40, -1, -1);
    chk("t1_busy_cycles", n, 24);
    chk("t1_dut_in_seq", bad, 0);
    chk("t1_done", done, 1);
    chk("t1_table", truth_table, 8'h40);
    chk("t1_match", match, 1);
    chk("t1_mis", mismatch_idx, 0);
    chk("t1_aborted", aborted, 0);
    chk("t1_dut_in_idle", dut_in, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_match_hold", match, 1);

    // expected differs at bit 3
    sweep(8'h48, -1, -1);
    chk("t2_busy_cycles", n, 24);
    chk("t2_table", truth_table, 8'h40);
    chk("t2_match", match, 0);
    chk("t2_mis", mismatch_idx, 3);
    tick();

    // abort during SETTLE of vector 4
    sweep(8'h40, -1, 12);
    chk("t3_cycles", n, 13);
    chk("t3_done", done, 1);
    chk("t3_aborted", aborted, 1);
    chk("t3_busy", busy, 0);
    chk("t3_table", truth_table, 8'h00);
    chk("t3_match", match, 0);
    chk("t3_mis", mismatch_idx, 4);
    tick();
    chk("t3_aborted_hold", aborted, 1);

    // start re-pulsed mid-sweep with a changed expected: no restart, original expected used
    sweep(8'h40, 6, -1);
    chk("t4_busy_cycles", n, 24);
    chk("t4_dut_in_seq", bad, 0);
    chk("t4_done", done, 1);
    chk("t4_match", match, 1);
    chk("t4_aborted", aborted, 0);
    tick();

    // async reset mid-sweep at vector 5
    expected = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("t5_pre_dut_in", dut_in, 5);
    chk("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_dut_in", dut_in, 0);
    chk("t5_table", truth_table, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
    sweep(8'h40, -1, -1);
    chk("t5_re_cycles", n, 24);
    chk("t5_re_table", truth_table, 8'h40);
    chk("t5_re_match", match, 1);
    tick();

    // small instance: XOR, 4 vectors x 2 cycles
    expected2 = 4'h6;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    bad = 0;
    while (busy2 && n < 100) begin
      if (dut_in2 !== 2'(n / 2)) bad++;
      tick();
      n++;
    end
    chk("t6_busy_cycles", n, 8);
    chk("t6_dut_in_seq", bad, 0);
    chk("t6_done", done2, 1);
    chk("t6_table", truth_table2, 4'h6);
    chk("t6_match", match2, 1);
    chk("t6_mis", mismatch_idx2, 0);
    tick();
    chk("t6_done_pulse", done2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
